qsfp_i2c_target: RTL and testbench
==================================

// Module: qsfp_i2c_target
// PURPOSE
//  I2C target (responder) emulating a QSFP module management interface: 7-bit address match, 8-bit byte pointer,
//  256-byte register file, auto-increment reads/writes. Serves as the far-end device for the QSFP I2C controller
//  path (board-level loopback and sim bench). Oversamples SCL/SDA on clk; no SCL-domain logic.
// PARAMETERS
//  DEV_ADDR    7'h50  7-bit target address matched (bits [7:1] of the address byte)
//  FILT_LEN    3      consecutive equal samples needed before a synchronized SCL/SDA level is accepted (1..7)
//  INIT_BYTE   8'h00  reset value of every register-file byte
// PORTS
//  clk         in   1  system clock, >= 20x SCL rate
//  rst         in   1  asynchronous, active-high reset
//  scl_i       in   1  SCL pad input (IOBUF O)
//  sda_i       in   1  SDA pad input (IOBUF O)
//  sda_o       out  1  SDA output data, constant 0 (open-drain)
//  sda_t       out  1  SDA tristate: 1 = release, 0 = drive low
//  loc_wr      in   1  local write strobe into register file (single cycle)
//  loc_addr    in   8  local write address
//  loc_wdata   in   8  local write data
//  i2c_wr      out  1  one-cycle pulse per byte committed from I2C
//  i2c_addr    out  8  register address of committed byte (valid with i2c_wr)
//  i2c_wdata   out  8  committed data (valid with i2c_wr)
//  busy        out  1  1 between detected START and STOP
// BEHAVIOUR
//  Input path: 2-FF sync per line, then FILT_LEN glitch filter; edges derived from filtered levels only.
//  START = filtered SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1. Either, in any state, aborts the
//  current byte. START (incl. repeated) -> ADDR; STOP -> IDLE, sda_t=1.
//  Bits sampled on SCL rising edge, MSB first; sda_t changes only on SCL falling edge (+1 clk after detect).
//  States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
//   ADDR: 8 bits; match [7:1]==DEV_ADDR -> ADDR_ACK (drive 0 for one SCL period); mismatch -> IGNORE (never drives).
//   ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RD_DATA, shift reg loaded from mem[ptr].
//   PTR: byte -> ptr, ACK, then WR_DATA. WR_DATA: byte -> mem[ptr] at end of ACK, i2c_wr pulse, ptr+1.
//   RD_DATA: drive bits of mem[ptr]; RD_ACK samples master ACK: 0 -> ptr+1, reload, RD_DATA; 1 (NACK) -> IGNORE.
//   IGNORE: sda_t=1 until START/STOP.
//  Pointer 8 bits, wraps 0xFF->0x00 on both read and write. ptr persists across transactions (current-address read).
//  Partial byte (fewer than 8 bits before START/STOP): discarded, no write, no ptr change.
//  loc_wr and I2C commit to same address in same cycle: I2C wins; loc_wr to mem[ptr] during RD_DATA does not
//  alter the byte already in flight.
//  Reset (async, any time): state IDLE, sda_t=1, sda_o=0, ptr=0, i2c_wr=0, i2c_addr=0, i2c_wdata=0, busy=0,
//  all mem bytes = INIT_BYTE; filters preset to 1 (bus idle), so no false START on release.
// CONFIGURATION
//  QSFP_I2C_TGT_WRPROT_EN defined: bytes 0x00-0x7F are read-only from I2C: write data ACKed, not stored,
//   no i2c_wr pulse, ptr still increments. loc_wr unaffected.
//  Undefined: all 256 bytes writable from I2C.
// TESTING
//  Write 0x50/W, ptr 0x80, data A5,3C, STOP -> 4 ACKs, mem[80]=A5, mem[81]=3C, two i2c_wr pulses, ptr=0x82.
//  Addr 0x51/W -> no ACK (SDA stays 1), sda_t=1 whole frame, mem unchanged.
//  Random read: W ptr 0x80, Sr, 0x50/R, read 2 bytes ACK+NACK -> A5 then 3C, sda_t=1 after NACK, ptr=0x82.
//  ptr 0xFF, write 11,22 -> mem[FF]=11, mem[00]=22 (no WRPROT) / mem[00] unchanged, ACKed (WRPROT).
//  STOP after 4 data bits, then 20ns SDA glitch with SCL=1 -> no write, no START/busy, ptr unchanged.
//  rst asserted mid RD_DATA while driving 0 -> sda_t=1 same cycle, ptr=0, next frame decodes normally.

Source files
------------

// File: rtl/qsfp_i2c_target.sv
// QSFP management I2C target: address match, byte pointer, 256-byte register file, auto-increment.
// Latency: SCL/SDA seen 2 sync + FILT_LEN filter clks late; sda_t moves 1 clk after a filtered SCL fall.
// Backpressure: none; the target never stretches SCL, and local writes are always accepted.
//
// Ports:
//   clk, rst             system clock (>= 20x SCL), asynchronous active-high reset
//   scl_i, sda_i         pad inputs, oversampled on clk
//   sda_o, sda_t         open-drain SDA: sda_o fixed 0, sda_t=0 pulls the line low
//   loc_wr/addr/wdata    local single-cycle write port into the register file
//   i2c_wr/addr/wdata    one-cycle notification of every byte stored from the bus
//   busy                 high from a detected START until a detected STOP
//
// Build option: define QSFP_I2C_TGT_WRPROT_EN to make bytes 0x00-0x7F read-only from I2C
// (data still ACKed and the pointer still advances, but nothing is stored and i2c_wr stays low).
`timescale 1ns/1ps

module qsfp_i2c_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         FILT_LEN  = 3,
    parameter logic [7:0] INIT_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    input  logic       loc_wr,
    input  logic [7:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic       i2c_wr,
    output logic [7:0] i2c_addr,
    output logic [7:0] i2c_wdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    // Filter accepts a new level on the FILT_LEN-th consecutive differing sample.
    localparam logic [2:0] FILT_LAST = 3'(FILT_LEN - 1);

    // Index 0 = SCL, index 1 = SDA.  Everything presets to 1 (idle bus) so
    // releasing reset can never look like a START.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt_q, filt_d, filt_p_q;
    logic [2:0] fcnt_q [2];
    logic [2:0] fcnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = 3'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] >= FILT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            filt_q   <= 2'b11;
            filt_p_q <= 2'b11;
            fcnt_q[0] <= 3'd0;
            fcnt_q[1] <= 3'd0;
        end else begin
            sync1_q  <= {sda_i, scl_i};
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            filt_p_q <= filt_q;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = filt_q[0] & ~filt_p_q[0];
    assign scl_fall  = ~filt_q[0] & filt_p_q[0];
    // SDA moving while SCL has been high for two samples is a bus condition, not data.
    assign start_det = scl_f & filt_p_q[0] & filt_p_q[1] & ~sda_f;
    assign stop_det  = scl_f & filt_p_q[0] & ~filt_p_q[1] & sda_f;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       sda_t_q, sda_t_d;
    logic       busy_q, busy_d;
    logic       i2c_wr_q, i2c_wr_d;
    logic [7:0] i2c_addr_q, i2c_addr_d;
    logic [7:0] i2c_wdata_q, i2c_wdata_d;

    logic [7:0] mem_q [256];
    logic       mem_we;
    logic [7:0] mem_waddr, mem_wdata;

    logic [7:0] full_byte, ptr_inc, rd_next;
    logic       wr_allow;

    assign full_byte = {shift_q[6:0], sda_f};
    assign ptr_inc   = ptr_q + 8'd1;
    assign rd_next   = mem_q[ptr_inc];

    always_comb begin
`ifdef QSFP_I2C_TGT_WRPROT_EN
        wr_allow = ptr_q[7];
`else
        wr_allow = 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ack_d       = ack_q;
        sda_t_d     = sda_t_q;
        busy_d      = busy_q;
        i2c_wr_d    = 1'b0;
        i2c_addr_d  = i2c_addr_q;
        i2c_wdata_d = i2c_wdata_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = shift_q;

        if (start_det) begin
            // Any partially received byte is simply dropped: nothing has been committed yet.
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            sda_t_d = 1'b1;
            busy_d  = 1'b1;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = full_byte;
                        cnt_d   = cnt_q + 4'd1;
                        // A foreign address is decided on the 8th bit; never ACK it.
                        if (state_q == ST_ADDR && cnt_q == 4'd7) begin
                            if (full_byte[7:1] == DEV_ADDR) begin
                                rw_d = sda_f;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_t_d = 1'b0;
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK :
                                  (state_q == ST_PTR)  ? ST_PTR_ACK  : ST_WR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            // Present the MSB on the same fall that ends the ACK.
                            shift_d = mem_q[ptr_q];
                            sda_t_d = mem_q[ptr_q][7];
                            state_d = ST_RD_DATA;
                        end else begin
                            sda_t_d = 1'b1;
                            state_d = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        ptr_d   = shift_q;
                        cnt_d   = 4'd0;
                        sda_t_d = 1'b1;
                        state_d = ST_WR_DATA;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (wr_allow) begin
                            mem_we      = 1'b1;
                            i2c_wr_d    = 1'b1;
                            i2c_addr_d  = ptr_q;
                            i2c_wdata_d = shift_q;
                        end
                        ptr_d   = ptr_inc;
                        cnt_d   = 4'd0;
                        sda_t_d = 1'b1;
                        state_d = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_t_d = 1'b1;
                            state_d = ST_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            sda_t_d = shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_f;
                    end else if (scl_fall) begin
                        // The byte has been sent either way, so the pointer advances even on NACK.
                        ptr_d = ptr_inc;
                        if (!ack_q) begin
                            shift_d = rd_next;
                            sda_t_d = rd_next[7];
                            cnt_d   = 4'd0;
                            state_d = ST_RD_DATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    sda_t_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'd0;
            ptr_q       <= 8'd0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b1;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            i2c_wr_q    <= 1'b0;
            i2c_addr_q  <= 8'd0;
            i2c_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_t_q     <= sda_t_d;
            busy_q      <= busy_d;
            i2c_wr_q    <= i2c_wr_d;
            i2c_addr_q  <= i2c_addr_d;
            i2c_wdata_q <= i2c_wdata_d;
        end
    end

    // The I2C write is issued last so it takes precedence on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= INIT_BYTE;
            end
        end else begin
            if (loc_wr) begin
                mem_q[loc_addr] <= loc_wdata;
            end
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
        end
    end

    assign sda_o     = 1'b0;
    assign sda_t     = sda_t_q;
    assign busy      = busy_q;
    assign i2c_wr    = i2c_wr_q;
    assign i2c_addr  = i2c_addr_q;
    assign i2c_wdata = i2c_wdata_q;

endmodule

// File: tb/tb_qsfp_i2c_target.sv
// Directed bench for qsfp_i2c_target: a bit-banged I2C controller drives the open-drain bus,
// and register contents / pointer are observed only through I2C reads and the i2c_wr port.
`timescale 1ns/1ps

module tb_qsfp_i2c_target;

    localparam int Q = 100;   // quarter SCL period in ns; clk is 10 ns

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       loc_wr = 1'b0;
    logic [7:0] loc_addr = 8'd0;
    logic [7:0] loc_wdata = 8'd0;
    logic       sda_o, sda_t, i2c_wr, busy;
    logic [7:0] i2c_addr, i2c_wdata;
    logic       sda_bus;

    assign sda_bus = sda_m & (sda_t | sda_o);

    qsfp_i2c_target dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .loc_wr    (loc_wr),
        .loc_addr  (loc_addr),
        .loc_wdata (loc_wdata),
        .i2c_wr    (i2c_wr),
        .i2c_addr  (i2c_addr),
        .i2c_wdata (i2c_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Byte-commit log and bus monitors.
    logic [15:0] wr_log [$];
    bit mon_en = 1'b0;
    bit saw_drive = 1'b0;
    bit saw_busy = 1'b0;

    always @(posedge clk) begin
        if (i2c_wr) wr_log.push_back({i2c_addr, i2c_wdata});
        if (mon_en) begin
            if (!sda_t) saw_drive = 1'b1;
            if (busy)   saw_busy  = 1'b1;
        end
    end

    task automatic bus_start;
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
        put_bit(nack);
    endtask

    task automatic loc_write(input logic [7:0] a, input logic [7:0] d);
        loc_addr = a; loc_wdata = d; loc_wr = 1'b1; #10; loc_wr = 1'b0; #10;
    endtask

    // Current-address read of one byte, NACKed.
    task automatic cur_read(input string tag, input logic [7:0] exp);
        logic       ack;
        logic [7:0] d;
        bus_start;
        put_byte(8'hA1, ack);
        chk_eq({tag, "_ack"}, 16'(ack), 16'h0);
        get_byte(1'b1, d);
        bus_stop;
        chk_eq(tag, 16'(d), 16'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         base;

        // Reset state
        #100; rst = 1'b0; #100;
        chk_eq("rst_sda_t",  16'(sda_t), 16'h1);
        chk_eq("rst_sda_o",  16'(sda_o), 16'h0);
        chk_eq("rst_busy",   16'(busy), 16'h0);
        chk_eq("rst_i2c_wr", 16'(i2c_wr), 16'h0);
        chk_eq("rst_i2c_addr",  16'(i2c_addr), 16'h0);
        chk_eq("rst_i2c_wdata", 16'(i2c_wdata), 16'h0);

        loc_write(8'h82, 8'h77);

        // Write 0x50/W, ptr 0x80, A5, 3C
        bus_start;
        chk_eq("wr_busy", 16'(busy), 16'h1);
        put_byte(8'hA0, ack); chk_eq("wr_ack_addr", 16'(ack), 16'h0);
        put_byte(8'h80, ack); chk_eq("wr_ack_ptr",  16'(ack), 16'h0);
        put_byte(8'hA5, ack); chk_eq("wr_ack_d0",   16'(ack), 16'h0);
        put_byte(8'h3C, ack); chk_eq("wr_ack_d1",   16'(ack), 16'h0);
        bus_stop;
        #Q;
        chk_eq("wr_busy_after_stop", 16'(busy), 16'h0);
        chk_eq("wr_pulses", 16'(wr_log.size()), 16'd2);
        chk_eq("wr_log0", wr_log[0], 16'h80A5);
        chk_eq("wr_log1", wr_log[1], 16'h813C);
        cur_read("wr_ptr_82", 8'h77);            // ptr now 0x83

        // Wrong address: never driven, nothing stored
        saw_drive = 1'b0; mon_en = 1'b1;
        bus_start;
        put_byte(8'hA2, ack); chk_eq("bad_addr_nack", 16'(ack), 16'h1);
        put_byte(8'h80, ack);
        put_byte(8'hEE, ack);
        bus_stop;
        mon_en = 1'b0;
        chk_eq("bad_addr_no_drive", 16'(saw_drive), 16'h0);
        chk_eq("bad_addr_no_wr", 16'(wr_log.size()), 16'd2);

        // Random read 0x80 with repeated START
        bus_start;
        put_byte(8'hA0, ack);
        put_byte(8'h80, ack);
        bus_start;
        put_byte(8'hA1, ack); chk_eq("rr_ack_addr", 16'(ack), 16'h0);
        get_byte(1'b0, d);    chk_eq("rr_byte0", 16'(d), 16'h00A5);
        get_byte(1'b1, d);    chk_eq("rr_byte1", 16'(d), 16'h003C);
        chk_eq("rr_release_after_nack", 16'(sda_t), 16'h1);
        bus_stop;
        cur_read("rr_ptr_82", 8'h77);            // ptr now 0x83
        chk_eq("rr_mem80_intact_no_wr", 16'(wr_log.size()), 16'd2);

        // Pointer wrap 0xFF -> 0x00 on write and read
        base = wr_log.size();
        bus_start;
        put_byte(8'hA0, ack);
        put_byte(8'hFF, ack);
        put_byte(8'h11, ack); chk_eq("wrap_ack_ff", 16'(ack), 16'h0);
        put_byte(8'h22, ack); chk_eq("wrap_ack_00", 16'(ack), 16'h0);
        bus_stop;
`ifdef QSFP_I2C_TGT_WRPROT_EN
        chk_eq("wrap_pulses", 16'(wr_log.size() - base), 16'd1);
`else
        chk_eq("wrap_pulses", 16'(wr_log.size() - base), 16'd2);
        chk_eq("wrap_log00", wr_log[base+1], 16'h0022);
`endif
        chk_eq("wrap_logff", wr_log[base], 16'hFF11);
        bus_start;
        put_byte(8'hA0, ack);
        put_byte(8'hFF, ack);
        bus_start;
        put_byte(8'hA1, ack);
        get_byte(1'b0, d); chk_eq("wrap_rd_ff", 16'(d), 16'h0011);
        get_byte(1'b1, d);
`ifdef QSFP_I2C_TGT_WRPROT_EN
        chk_eq("wrap_rd_00", 16'(d), 16'h0000);
`else
        chk_eq("wrap_rd_00", 16'(d), 16'h0022);
`endif
        bus_stop;

        // Partial data byte then a 20 ns SDA glitch with SCL high
        bus_start;
        put_byte(8'hA0, ack);
        put_byte(8'h90, ack);
        bus_stop;
        loc_write(8'h90, 8'h5A);
        base = wr_log.size();
        bus_start;
        put_byte(8'hA0, ack);
        put_byte(8'h10, ack);                    // ptr <- 0x10
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        bus_stop;
        #Q;
        saw_busy = 1'b0; mon_en = 1'b1;
        sda_m = 1'b0; #20; sda_m = 1'b1;
        #(2*Q);
        mon_en = 1'b0;
        chk_eq("glitch_no_busy", 16'(saw_busy), 16'h0);
        chk_eq("partial_no_wr", 16'(wr_log.size() - base), 16'd0);
        loc_write(8'h10, 8'hC3);
        cur_read("partial_ptr_10", 8'hC3);

        // Reset while the target drives a 0 data bit
        loc_write(8'h40, 8'h3C);
        bus_start;
        put_byte(8'hA0, ack);
        put_byte(8'h40, ack);
        bus_start;
        put_byte(8'hA1, ack);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
        chk_eq("mid_rd_driving", 16'(sda_t), 16'h0);
        rst = 1'b1; #1;
        chk_eq("mid_rd_rst_release", 16'(sda_t), 16'h1);
        chk_eq("mid_rd_rst_busy", 16'(busy), 16'h0);
        sda_m = 1'b1; scl_m = 1'b1;
        #100; rst = 1'b0; #200;
        chk_eq("post_rst_no_start", 16'(busy), 16'h0);
        loc_write(8'h00, 8'h66);
        cur_read("post_rst_ptr_00", 8'h66);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
